// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues instruction-memory reads and
// presents {PC, PC+4, instruction} to the IF/ID register.
// Optional performance counters are compiled in when IF_PERF_COUNT_EN is defined.
//
// Handshakes:
//   IMEM side  - IMEM_READ high requests the word at IMEM_ADDRESS; IMEM_READDATA
//                is valid only in a cycle where IMEM_READ=1 and IMEM_BUSYWAIT=0.
//   IF/ID side - BUSYWAIT_OUT low means IF/ID loads {PC_OUT, INSTRUCTION_OUT}
//                at this posedge; high means IF/ID must hold its contents.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDRESS,
    input  logic [31:0] IMEM_READDATA,
    input  logic        IMEM_BUSYWAIT,
    output logic [31:0] PC_OUT,
    output logic [31:0] PC_PLUS_FOUR_OUT,
    output logic [31:0] INSTRUCTION_OUT,
    output logic        BUSYWAIT_OUT,
`ifdef IF_PERF_COUNT_EN
    output logic [31:0] FETCH_COUNT,
    output logic [31:0] STALL_COUNT,
`endif
    output logic [1:0]  DBG_STATE
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_WAIT  = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_hold;
    logic [31:0] w_next_pc;
    logic [31:0] w_pc_plus_four;
    logic [31:0] w_branch_pc;
    logic [31:0] w_instr;
    logic        w_capture;
    logic        w_busy;
    logic        w_read;

    // Low two bits are masked rather than sliced so the full target is consumed.
    assign w_branch_pc    = BRANCH_TARGET & 32'hFFFF_FFFC;
    assign w_pc_plus_four = r_pc + 32'd4;

    assign IMEM_ADDRESS     = r_pc & 32'hFFFF_FFFC;
    assign IMEM_READ        = w_read;
    assign PC_OUT           = r_pc;
    assign PC_PLUS_FOUR_OUT = w_pc_plus_four;
    assign INSTRUCTION_OUT  = w_instr;
    assign BUSYWAIT_OUT     = w_busy;
    assign DBG_STATE        = r_state;

    // State, PC and hold buffer; reset is asynchronous and discards any pending fetch.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_FETCH;
            r_pc    <= RESET_PC;
            r_hold  <= NOP_INSTR;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            if (w_capture) begin
                r_hold <= IMEM_READDATA;
            end
        end
    end

    // Next state, next PC and IF/ID-facing outputs; branch overrides stall and memory wait.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_busy       = 1'b1;
        w_instr      = r_hold;
        w_capture    = 1'b0;
        w_read       = (r_state != ST_HOLD);

        if (RESET) begin
            w_read       = 1'b0;
            w_instr      = NOP_INSTR;
            w_next_state = ST_FETCH;
            w_next_pc    = RESET_PC;
        end else if (BRANCH_TAKEN) begin
            // Flush: the NOP is loaded into IF/ID and any in-flight read is dropped.
            w_instr      = NOP_INSTR;
            w_busy       = 1'b0;
            w_next_pc    = w_branch_pc;
            w_next_state = ST_FETCH;
        end else begin
            case (r_state)
                ST_FETCH, ST_WAIT: begin
                    if (IMEM_BUSYWAIT) begin
                        w_next_state = ST_WAIT;
                    end else begin
                        w_instr   = IMEM_READDATA;
                        w_capture = 1'b1;
                        if (STALL) begin
                            w_next_state = ST_HOLD;
                        end else begin
                            w_busy       = 1'b0;
                            w_next_pc    = w_pc_plus_four;
                            w_next_state = ST_FETCH;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        w_busy       = 1'b0;
                        w_next_pc    = w_pc_plus_four;
                        w_next_state = ST_FETCH;
                    end
                end
                default: begin
                    w_next_state = ST_FETCH;
                end
            endcase
        end
    end

`ifdef IF_PERF_COUNT_EN
    logic [31:0] r_fetch_count;
    logic [31:0] r_stall_count;

    assign FETCH_COUNT = r_fetch_count;
    assign STALL_COUNT = r_stall_count;

    // Count real instruction loads (flush NOPs excluded) and IF/ID hold cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_fetch_count <= 32'd0;
            r_stall_count <= 32'd0;
        end else begin
            if (!w_busy && !BRANCH_TAKEN) begin
                r_fetch_count <= r_fetch_count + 32'd1;
            end
            if (w_busy) begin
                r_stall_count <= r_stall_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h00000000;
    localparam logic [31:0] NOP    = 32'h00000013;
    localparam logic [31:0] JUNK   = 32'hDEADBEEF;

    logic        CLK;
    logic        RESET;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDRESS;
    logic [31:0] IMEM_READDATA;
    logic        IMEM_BUSYWAIT;
    logic [31:0] PC_OUT;
    logic [31:0] PC_PLUS_FOUR_OUT;
    logic [31:0] INSTRUCTION_OUT;
    logic        BUSYWAIT_OUT;
    logic [1:0]  DBG_STATE;
`ifdef IF_PERF_COUNT_EN
    logic [31:0] FETCH_COUNT;
    logic [31:0] STALL_COUNT;
`endif

    int n_total;
    int n_bad;

    // Instruction memory contents: fixed words at a few addresses, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h00000000: return 32'h00A00093;
            32'h00000004: return 32'h00100113;
            32'h00000020: return 32'h00208233;
            default:      return {a[15:0] ^ 16'h5A5A, a[31:16]} + 32'h13;
        endcase
    endfunction

    // Memory returns junk while busy so premature use of the data is visible.
    assign IMEM_READDATA = IMEM_BUSYWAIT ? JUNK : mem_word(IMEM_ADDRESS);

    instruction_fetch_unit #(
        .RESET_PC  (RST_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .STALL            (STALL),
        .BRANCH_TAKEN     (BRANCH_TAKEN),
        .BRANCH_TARGET    (BRANCH_TARGET),
        .IMEM_READ        (IMEM_READ),
        .IMEM_ADDRESS     (IMEM_ADDRESS),
        .IMEM_READDATA    (IMEM_READDATA),
        .IMEM_BUSYWAIT    (IMEM_BUSYWAIT),
        .PC_OUT           (PC_OUT),
        .PC_PLUS_FOUR_OUT (PC_PLUS_FOUR_OUT),
        .INSTRUCTION_OUT  (INSTRUCTION_OUT),
        .BUSYWAIT_OUT     (BUSYWAIT_OUT),
`ifdef IF_PERF_COUNT_EN
        .FETCH_COUNT      (FETCH_COUNT),
        .STALL_COUNT      (STALL_COUNT),
`endif
        .DBG_STATE        (DBG_STATE)
    );

    // Clock
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Driver: inputs change 1 after posedge, outputs sampled at the following negedge.
    task automatic cyc(input logic st, input logic bw, input logic br, input logic [31:0] tgt);
        @(posedge CLK);
        #1;
        RESET         = 1'b0;
        STALL         = st;
        IMEM_BUSYWAIT = bw;
        BRANCH_TAKEN  = br;
        BRANCH_TARGET = tgt;
        @(negedge CLK);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        #1;
        RESET         = 1'b1;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        @(negedge CLK);
    endtask

    task automatic test_reset();
        do_reset();
        n_total += 5;
        if (IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL rst_read got %b want 0", IMEM_READ); end
        if (BUSYWAIT_OUT !== 1'b1) begin n_bad++; $display("FAIL rst_busy got %b want 1", BUSYWAIT_OUT); end
        if (INSTRUCTION_OUT !== NOP) begin n_bad++; $display("FAIL rst_instr got %h want %h", INSTRUCTION_OUT, NOP); end
        if (PC_OUT !== RST_PC) begin n_bad++; $display("FAIL rst_pc got %h want %h", PC_OUT, RST_PC); end
        if (PC_PLUS_FOUR_OUT !== RST_PC + 32'd4) begin n_bad++; $display("FAIL rst_pc4 got %h want %h", PC_PLUS_FOUR_OUT, RST_PC + 32'd4); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_pc;
        do_reset();
        exp_pc = RST_PC;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0, 32'h0);
            n_total += 4;
            if (PC_OUT !== exp_pc) begin n_bad++; $display("FAIL seq_pc[%0d] got %h want %h", i, PC_OUT, exp_pc); end
            if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL seq_busy[%0d] got %b want 0", i, BUSYWAIT_OUT); end
            if (INSTRUCTION_OUT !== mem_word(exp_pc)) begin n_bad++; $display("FAIL seq_instr[%0d] got %h want %h", i, INSTRUCTION_OUT, mem_word(exp_pc)); end
            if (IMEM_READ !== 1'b1) begin n_bad++; $display("FAIL seq_read[%0d] got %b want 1", i, IMEM_READ); end
            exp_pc = exp_pc + 32'd4;
        end
    endtask

    task automatic test_busywait();
        cyc(1'b0, 1'b0, 1'b1, 32'h10);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 32'h0);
            n_total += 2;
            if (BUSYWAIT_OUT !== 1'b1) begin n_bad++; $display("FAIL bw_busy[%0d] got %b want 1", i, BUSYWAIT_OUT); end
            if (PC_OUT !== 32'h10) begin n_bad++; $display("FAIL bw_pc[%0d] got %h want 00000010", i, PC_OUT); end
        end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL bw_load got %b want 0", BUSYWAIT_OUT); end
        if (INSTRUCTION_OUT !== mem_word(32'h10)) begin n_bad++; $display("FAIL bw_instr got %h want %h", INSTRUCTION_OUT, mem_word(32'h10)); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (PC_OUT !== 32'h14) begin n_bad++; $display("FAIL bw_next_pc got %h want 00000014", PC_OUT); end
    endtask

    task automatic test_stall();
        cyc(1'b0, 1'b0, 1'b1, 32'h20);
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (BUSYWAIT_OUT !== 1'b1) begin n_bad++; $display("FAIL st_busy0 got %b want 1", BUSYWAIT_OUT); end
        if (INSTRUCTION_OUT !== 32'h00208233) begin n_bad++; $display("FAIL st_instr0 got %h want 00208233", INSTRUCTION_OUT); end
        cyc(1'b1, 1'b0, 1'b0, 32'h0);
        n_total += 4;
        if (IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL st_hold_read got %b want 0", IMEM_READ); end
        if (INSTRUCTION_OUT !== 32'h00208233) begin n_bad++; $display("FAIL st_instr1 got %h want 00208233", INSTRUCTION_OUT); end
        if (BUSYWAIT_OUT !== 1'b1) begin n_bad++; $display("FAIL st_busy1 got %b want 1", BUSYWAIT_OUT); end
        if (PC_OUT !== 32'h20) begin n_bad++; $display("FAIL st_pc1 got %h want 00000020", PC_OUT); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 3;
        if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL st_release got %b want 0", BUSYWAIT_OUT); end
        if (INSTRUCTION_OUT !== 32'h00208233) begin n_bad++; $display("FAIL st_instr2 got %h want 00208233", INSTRUCTION_OUT); end
        if (PC_OUT !== 32'h20) begin n_bad++; $display("FAIL st_pc2 got %h want 00000020", PC_OUT); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (PC_OUT !== 32'h24) begin n_bad++; $display("FAIL st_pc3 got %h want 00000024", PC_OUT); end
    endtask

    task automatic test_branch_wait();
        cyc(1'b0, 1'b0, 1'b1, 32'h40);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 1'b1, 32'h103);
        n_total += 2;
        if (INSTRUCTION_OUT !== NOP) begin n_bad++; $display("FAIL br_instr got %h want %h", INSTRUCTION_OUT, NOP); end
        if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL br_busy got %b want 0", BUSYWAIT_OUT); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (IMEM_ADDRESS !== 32'h100) begin n_bad++; $display("FAIL br_addr got %h want 00000100", IMEM_ADDRESS); end
        if (INSTRUCTION_OUT !== mem_word(32'h100)) begin n_bad++; $display("FAIL br_stale got %h want %h", INSTRUCTION_OUT, mem_word(32'h100)); end
    endtask

    task automatic test_wrap();
        cyc(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 3;
        if (PC_OUT !== 32'hFFFFFFFC) begin n_bad++; $display("FAIL wrap_pc got %h want fffffffc", PC_OUT); end
        if (PC_PLUS_FOUR_OUT !== 32'h0) begin n_bad++; $display("FAIL wrap_pc4 got %h want 00000000", PC_PLUS_FOUR_OUT); end
        if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL wrap_busy got %b want 0", BUSYWAIT_OUT); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total++;
        if (PC_OUT !== 32'h0) begin n_bad++; $display("FAIL wrap_next got %h want 00000000", PC_OUT); end
    endtask

    task automatic test_async_reset();
        cyc(1'b0, 1'b0, 1'b1, 32'h80);
        cyc(1'b0, 1'b1, 1'b0, 32'h0);
        #2;
        RESET = 1'b1;
        #1;
        n_total += 3;
        if (PC_OUT !== RST_PC) begin n_bad++; $display("FAIL ares_pc got %h want %h", PC_OUT, RST_PC); end
        if (IMEM_READ !== 1'b0) begin n_bad++; $display("FAIL ares_read got %b want 0", IMEM_READ); end
        if (INSTRUCTION_OUT !== NOP) begin n_bad++; $display("FAIL ares_instr got %h want %h", INSTRUCTION_OUT, NOP); end
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 3;
        if (IMEM_ADDRESS !== RST_PC) begin n_bad++; $display("FAIL ares_addr got %h want %h", IMEM_ADDRESS, RST_PC); end
        if (INSTRUCTION_OUT !== mem_word(RST_PC)) begin n_bad++; $display("FAIL ares_first got %h want %h", INSTRUCTION_OUT, mem_word(RST_PC)); end
        if (BUSYWAIT_OUT !== 1'b0) begin n_bad++; $display("FAIL ares_busy got %b want 0", BUSYWAIT_OUT); end
    endtask

    // Reference model: the PC of the instruction owed to IF/ID next and whether
    // its word has already been returned by memory.
    task automatic test_random();
        logic [31:0] m_pc;
        logic        m_got;
        logic        st, bw, br, load;
        logic [31:0] tgt;
        do_reset();
        m_pc  = RST_PC;
        m_got = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            st  = ($urandom_range(0, 3) == 0);
            bw  = ($urandom_range(0, 2) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = $urandom;
            cyc(st, bw, br, tgt);
            load = br || (!st && (m_got || !bw));
            n_total += 5;
            if (PC_OUT !== m_pc) begin n_bad++; $display("FAIL rnd_pc[%0d] got %h want %h", i, PC_OUT, m_pc); end
            if (PC_PLUS_FOUR_OUT !== m_pc + 32'd4) begin n_bad++; $display("FAIL rnd_pc4[%0d] got %h want %h", i, PC_PLUS_FOUR_OUT, m_pc + 32'd4); end
            if (IMEM_ADDRESS !== {m_pc[31:2], 2'b00}) begin n_bad++; $display("FAIL rnd_addr[%0d] got %h want %h", i, IMEM_ADDRESS, {m_pc[31:2], 2'b00}); end
            if (IMEM_READ !== !m_got) begin n_bad++; $display("FAIL rnd_read[%0d] got %b want %b", i, IMEM_READ, !m_got); end
            if (BUSYWAIT_OUT !== !load) begin n_bad++; $display("FAIL rnd_busy[%0d] got %b want %b", i, BUSYWAIT_OUT, !load); end
            if (br) begin
                n_total++;
                if (INSTRUCTION_OUT !== NOP) begin n_bad++; $display("FAIL rnd_flush[%0d] got %h want %h", i, INSTRUCTION_OUT, NOP); end
            end else if (m_got || !bw) begin
                n_total++;
                if (INSTRUCTION_OUT !== mem_word(m_pc)) begin n_bad++; $display("FAIL rnd_instr[%0d] got %h want %h", i, INSTRUCTION_OUT, mem_word(m_pc)); end
            end
            if (br) begin
                m_pc  = {tgt[31:2], 2'b00};
                m_got = 1'b0;
            end else if (load) begin
                m_pc  = m_pc + 32'd4;
                m_got = 1'b0;
            end else if (!bw) begin
                m_got = 1'b1;
            end
        end
    endtask

`ifdef IF_PERF_COUNT_EN
    task automatic test_perf();
        do_reset();
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b1, 32'h200);
        cyc(1'b0, 1'b0, 1'b0, 32'h0);
        n_total += 2;
        if (FETCH_COUNT !== 32'd5) begin n_bad++; $display("FAIL perf_fetch got %0d want 5", FETCH_COUNT); end
        if (STALL_COUNT !== 32'd3) begin n_bad++; $display("FAIL perf_stall got %0d want 3", STALL_COUNT); end
    endtask
`endif

    initial begin
        n_total       = 0;
        n_bad         = 0;
        RESET         = 1'b1;
        STALL         = 1'b0;
        IMEM_BUSYWAIT = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = 32'h0;
        test_reset();
        test_sequential();
        test_busywait();
        test_stall();
        test_branch_wait();
        test_wrap();
        test_async_reset();
        test_random();
`ifdef IF_PERF_COUNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, PC value loaded on reset.
REQ-002 SHALL have parameter NOP_INSTR, default 32'h00000013, instruction injected on flush.
REQ-003 SHALL have port CLK  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port RESET  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port STALL  input  1  downstream hazard hold; PC not advanced while high.
REQ-006 SHALL have port BRANCH_TAKEN  input  1  redirect request from execute.
REQ-007 SHALL have port BRANCH_TARGET  input  32  redirect address.
REQ-008 SHALL have port IMEM_READ  output  1  instruction memory read request.
REQ-009 SHALL have port IMEM_ADDRESS  output  32  word-aligned fetch address.
REQ-010 SHALL have port IMEM_READDATA  input  32  instruction word from memory.
REQ-011 SHALL have port IMEM_BUSYWAIT  input  1  memory not ready; READDATA valid only when low.
REQ-012 SHALL have port PC_OUT  output  32  PC of instruction presented to the IF/ID register.
REQ-013 SHALL have port PC_PLUS_FOUR_OUT  output  32  PC_OUT + 4.
REQ-014 SHALL have port INSTRUCTION_OUT  output  32  instruction presented to the IF/ID register.
REQ-015 SHALL have port BUSYWAIT_OUT  output  1  high = IF/ID must hold; low = IF/ID loads this cycle.

Function
REQ-016 SHALL implement FSM states FETCH, WAIT, HOLD; PC held in a 32-bit register.
REQ-017 SHALL drive IMEM_ADDRESS = {PC[31:2],2'b00}; IMEM_READ = 1 in FETCH and WAIT, 0 in HOLD.
REQ-018 FETCH/WAIT with IMEM_BUSYWAIT=1: BUSYWAIT_OUT=1, PC unchanged, next state WAIT.
REQ-019 FETCH/WAIT with IMEM_BUSYWAIT=0: INSTRUCTION_OUT=IMEM_READDATA combinationally, word captured into hold buffer at posedge.
REQ-020 Same case with STALL=0: BUSYWAIT_OUT=0, PC<=PC+4, next FETCH; with STALL=1: BUSYWAIT_OUT=1, PC held, next HOLD.
REQ-021 HOLD: INSTRUCTION_OUT=hold buffer, no memory read; STALL=1 stays HOLD with BUSYWAIT_OUT=1; STALL=0 sets BUSYWAIT_OUT=0, PC<=PC+4, next FETCH.
REQ-022 PC_OUT=PC register, PC_PLUS_FOUR_OUT=PC+4, modulo 2^32 (32'hFFFFFFFC wraps to 0).
REQ-023 BRANCH_TAKEN=1 in any state: INSTRUCTION_OUT=NOP_INSTR, BUSYWAIT_OUT=0, PC<={BRANCH_TARGET[31:2],2'b00}, next FETCH; priority over STALL and IMEM_BUSYWAIT.
REQ-024 Branch during WAIT: in-flight read abandoned; its data SHALL never reach INSTRUCTION_OUT.
REQ-025 Exactly one IF/ID load (BUSYWAIT_OUT=0 edge) per delivered instruction; no duplicates, no skips.

Reset
REQ-026 RESET high SHALL immediately set PC=RESET_PC, state FETCH, hold buffer=NOP_INSTR, independent of CLK.
REQ-027 While RESET high: IMEM_READ=0, BUSYWAIT_OUT=1, INSTRUCTION_OUT=NOP_INSTR, PC_OUT=RESET_PC.
REQ-028 Reset asserted mid-WAIT or mid-HOLD SHALL discard pending fetch; first fetch after release is RESET_PC.

Configuration
REQ-029 Macro IF_PERF_COUNT_EN defined: SHALL add outputs FETCH_COUNT[31:0] (increments per IF/ID load of a non-flush instruction) and STALL_COUNT[31:0] (increments per non-reset cycle with BUSYWAIT_OUT=1); both reset to 0, wrap at 2^32.
REQ-030 Macro IF_PERF_COUNT_EN undefined: counter ports and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 Reset release, IMEM zero-wait returning 0x00A00093 at 0, 0x00100113 at 4 -> PC_OUT 0,4,8 on consecutive cycles, BUSYWAIT_OUT=0 each cycle.
REQ-032 IMEM_BUSYWAIT high 3 cycles at PC=0x10 -> BUSYWAIT_OUT=1 three cycles, PC_OUT stays 0x10, then one load of word at 0x10.
REQ-033 STALL high 2 cycles as word 0x00208233 arrives at PC=0x20 -> IMEM_READ=0 in HOLD, INSTRUCTION_OUT stays 0x00208233, PC 0x24 only after STALL drops.
REQ-034 BRANCH_TAKEN, target 0x103, during WAIT at PC=0x40 -> INSTRUCTION_OUT=0x00000013 with BUSYWAIT_OUT=0, next IMEM_ADDRESS=0x100, stale 0x40 data never delivered.
REQ-035 PC=0xFFFFFFFC delivered -> PC_PLUS_FOUR_OUT=0, next PC_OUT=0; RESET pulsed mid-clock -> PC_OUT=RESET_PC before next edge.
REQ-036 With IF_PERF_COUNT_EN: 5 deliveries, 3 busywait cycles, 1 flush -> FETCH_COUNT=5, STALL_COUNT=3.
